mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Parametrised multi-cycle controller for the 16-bit processor family. It replaces the fixed 2-bit-opcode controller and adds six things: BLT, JMP and HALT opcodes, an illegal-opcode trap, and ready/valid wait-state handshakes on instruction and data memory. All opcode, register-field and ALU-op widths are parametrised. It sits between the IR/PC/register-file/ALU datapath and the two memories, and drives all write enables and both data-bus selects.

## Interface
- INSTRUCTION_LEN, 16, instruction width; must equal OPC_W + 3*REG_W.
- OPC_W, 4, opcode field width (instruction MSBs).
- REG_W, 4, width of the rd/offset, rs1 and rs2 fields, in that order below the opcode.
- ALU_OP_W, 2, alu_op width.
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instruction  in  INSTRUCTION_LEN  IR contents.
- zero, neg  in  1 each  combinational ALU flags.
- im_ready  in  1  instruction memory has data for the current PC.
- dm_ready  in  1  data memory has completed the current access.
- pc_wr_en, pc_src, ir_wr_en, rf_wr_en, tr1_wr_en, tr2_wr_en, alu_en  out  1 each  datapath enables.
- db_0_s, db_1_s  out  4 each  bus selects.
- alu_op  out  ALU_OP_W  ALU operation.
- im_req, dm_rd_en, dm_wr_en  out  1 each  memory requests.
- halted, illegal  out  1 each  sticky status.

## Operation
- Opcode decode: 0000–0011 is R-format, with alu_op taken from the low ALU_OP_W opcode bits. 0100 BEQ, 0101 BLT, 0110 LD, 0111 SD, 1000 JMP, 1111 HALT. Every other code is illegal.
- Offset is the rd field, sign-extended by the datapath. ALU ops: ADD=0, SUB=1, OR=2, AND=3.
- Outputs are Moore per state, except that ir_wr_en is qualified by im_ready. Every enable not listed for a state is 0. An unused bus select is driven 0 (never x). pc_src is 0 unless stated.
- States and transitions:
  - RESET: all outputs 0. Goes to FETCH.
  - FETCH: im_req=1, db_0_s=PC. While im_ready=0, stay. When im_ready=1, assert ir_wr_en and go to DECODE.
  - DECODE: R, BEQ, BLT, LD and SD go to RD_A. JMP goes to BR_PC. HALT goes to HALT. Illegal goes to TRAP.
  - RD_A: db_0_s=RS1, db_1_s=RS1, tr1_wr_en.
  - RD_B: tr2_wr_en. For R/BEQ/BLT, db_0_s=RS2 and db_1_s=RS2. For LD/SD, db_1_s=OFF. Next state is EXEC (R), CMP (branches) or ADDR (LD/SD).
  - EXEC: alu_en, opcode alu_op, db_1_s=ALU, tr2_wr_en. Goes to WB.
  - CMP: alu_en, alu_op=SUB. Taken when (BEQ and zero) or (BLT and neg); taken goes to BR_PC, otherwise PC_INC.
  - BR_PC: db_1_s=PC, tr1_wr_en.
  - BR_OFF: db_1_s=OFF, tr2_wr_en.
  - BR_UPD: alu_en, alu_op=ADD, pc_wr_en, pc_src=1, db_0_s=PCMUX, db_1_s=ALU. Goes to FETCH.
  - ADDR: alu_en, alu_op=ADD, db_1_s=ALU, tr2_wr_en. LD goes to MEM_RD; SD goes to ST_DATA.
  - MEM_RD: dm_rd_en held until dm_ready. In the dm_ready cycle, db_1_s=DM and tr1_wr_en, then go to WB.
  - ST_DATA: db_0_s=RS2, db_1_s=RS2, tr1_wr_en.
  - MEM_WR: dm_wr_en held until dm_ready. Goes to PC_INC.
  - WB: rf_wr_en, db_0_s=RD. db_1_s=TR2 for R-format, TR1 for LD. Goes to PC_INC.
  - PC_INC: pc_wr_en, pc_src=0, db_0_s=PCMUX. Goes to FETCH.
  - HALT: halted=1. Terminal until rst.
  - TRAP: illegal=1. Terminal until rst.
- Bus select codes: PC=0, IPR=1, RS1=2, RS2=3, OFF=4, ALU=5, PCMUX=6, RD=7, TR2=10, TR1=11, DM=14.

## Timing
- rst high: state is RESET and every output is 0, asynchronously. First FETCH is on the first edge after rst falls.
- Cycles per instruction with zero wait states:
  - R-format: 7.
  - Branch not taken: 6.
  - Branch taken: 8.
  - LD: 8.
  - SD: 8.
  - JMP: 5.
- Each cycle with im_ready=0 in FETCH, or dm_ready=0 in MEM_RD/MEM_WR, adds exactly one cycle. Request outputs stay asserted and stable during the wait.
- A ready input asserted outside its waiting state is ignored.
- zero and neg are sampled only in CMP.
- rst asserted mid-instruction or mid-wait: immediate return to RESET. No pending pc_wr_en, rf_wr_en or dm_wr_en may survive.
- halted and illegal are never both 1.

## Structure
- Package mc_pkg holds the state enum, opcode constants, bus-select constants and ALU-op constants.
- Sub-module mc_decode (combinational) classifies the opcode into is_r, is_beq, is_blt, is_ld, is_sd, is_jmp, is_halt and is_illegal.

## Test plan
- R-format ADD (0000), im_ready=1 throughout → 7 cycles; rf_wr_en only in WB with db_1_s=10; pc_wr_en only in PC_INC.
- BEQ with zero=1, then with zero=0 → 8 cycles with pc_src=1 in BR_UPD; 6 cycles with pc_src=0.
- LD with dm_ready low for 3 cycles → dm_rd_en high for 4 cycles; tr1_wr_en with db_1_s=14 in the dm_ready cycle; 11 cycles total.
- SD, then opcode 1010 → dm_wr_en only in MEM_WR; illegal=1 held and no further im_req.
- HALT; separately, rst asserted during MEM_WR → halted=1 held; rst forces all outputs to 0 at once, and FETCH follows after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states, opcodes,
// ALU operations and data-bus select codes.
package mc_pkg;

  typedef enum logic [4:0] {
    StReset,
    StFetch,
    StDecode,
    StRdA,
    StRdB,
    StExec,
    StCmp,
    StBrPc,
    StBrOff,
    StBrUpd,
    StAddr,
    StMemRd,
    StStData,
    StMemWr,
    StWb,
    StPcInc,
    StHalt,
    StTrap
  } state_e;

  // Opcodes 0..OpcRLast are R-format; the ALU op is their low bits.
  localparam int unsigned OpcRLast = 3;
  localparam int unsigned OpcBeq   = 4;
  localparam int unsigned OpcBlt   = 5;
  localparam int unsigned OpcLd    = 6;
  localparam int unsigned OpcSd    = 7;
  localparam int unsigned OpcJmp   = 8;
  localparam int unsigned OpcHalt  = 15;

  localparam int unsigned AluAdd = 0;
  localparam int unsigned AluSub = 1;
  localparam int unsigned AluOr  = 2;
  localparam int unsigned AluAnd = 3;

  localparam logic [3:0] DbPc    = 4'd0;
  localparam logic [3:0] DbIpr   = 4'd1;
  localparam logic [3:0] DbRs1   = 4'd2;
  localparam logic [3:0] DbRs2   = 4'd3;
  localparam logic [3:0] DbOff   = 4'd4;
  localparam logic [3:0] DbAlu   = 4'd5;
  localparam logic [3:0] DbPcmux = 4'd6;
  localparam logic [3:0] DbRd    = 4'd7;
  localparam logic [3:0] DbTr2   = 4'd10;
  localparam logic [3:0] DbTr1   = 4'd11;
  localparam logic [3:0] DbDm    = 4'd14;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: exactly one of the is_* flags is high for any opcode.
module mc_decode
  import mc_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_r,
  output logic             is_beq,
  output logic             is_blt,
  output logic             is_ld,
  output logic             is_sd,
  output logic             is_jmp,
  output logic             is_halt,
  output logic             is_illegal
);

  always_comb begin
    is_r       = (opcode <= OPC_W'(OpcRLast));
    is_beq     = (opcode == OPC_W'(OpcBeq));
    is_blt     = (opcode == OPC_W'(OpcBlt));
    is_ld      = (opcode == OPC_W'(OpcLd));
    is_sd      = (opcode == OPC_W'(OpcSd));
    is_jmp     = (opcode == OPC_W'(OpcJmp));
    is_halt    = (opcode == OPC_W'(OpcHalt));
    is_illegal = !(is_r || is_beq || is_blt || is_ld || is_sd || is_jmp || is_halt);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle controller for the 16-bit processor: sequences fetch/decode/execute,
// drives datapath enables, bus selects and memory requests with ready/valid wait states.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned INSTRUCTION_LEN = 16,
  parameter int unsigned OPC_W           = 4,
  parameter int unsigned REG_W           = 4,
  parameter int unsigned ALU_OP_W        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INSTRUCTION_LEN-1:0] instruction,
  input  logic                       zero,
  input  logic                       neg,
  input  logic                       im_ready,
  input  logic                       dm_ready,
  output logic                       pc_wr_en,
  output logic                       pc_src,
  output logic                       ir_wr_en,
  output logic                       rf_wr_en,
  output logic                       tr1_wr_en,
  output logic                       tr2_wr_en,
  output logic                       alu_en,
  output logic [3:0]                 db_0_s,
  output logic [3:0]                 db_1_s,
  output logic [ALU_OP_W-1:0]        alu_op,
  output logic                       im_req,
  output logic                       dm_rd_en,
  output logic                       dm_wr_en,
  output logic                       halted,
  output logic                       illegal
);

  state_e state_q, state_d;

  logic [OPC_W-1:0] opcode;
  logic is_r, is_beq, is_blt, is_ld, is_sd, is_jmp, is_halt, is_illegal;

  assign opcode = instruction[INSTRUCTION_LEN-1 -: OPC_W];

  // Register fields are routed by the datapath; the controller never looks at them.
  logic unused_fields;
  assign unused_fields = ^instruction[3*REG_W-1:0];

  mc_decode #(
    .OPC_W(OPC_W)
  ) u_decode (
    .opcode    (opcode),
    .is_r      (is_r),
    .is_beq    (is_beq),
    .is_blt    (is_blt),
    .is_ld     (is_ld),
    .is_sd     (is_sd),
    .is_jmp    (is_jmp),
    .is_halt   (is_halt),
    .is_illegal(is_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_wr_en  = 1'b0;
    pc_src    = 1'b0;
    ir_wr_en  = 1'b0;
    rf_wr_en  = 1'b0;
    tr1_wr_en = 1'b0;
    tr2_wr_en = 1'b0;
    alu_en    = 1'b0;
    db_0_s    = DbPc;
    db_1_s    = DbPc;
    alu_op    = '0;
    im_req    = 1'b0;
    dm_rd_en  = 1'b0;
    dm_wr_en  = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        im_req = 1'b1;
        db_0_s = DbPc;
        if (im_ready) begin
          ir_wr_en = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (is_jmp) begin
          state_d = StBrPc;
        end else if (is_halt) begin
          state_d = StHalt;
        end else if (is_illegal) begin
          state_d = StTrap;
        end else begin
          state_d = StRdA;
        end
      end
      StRdA: begin
        db_0_s    = DbRs1;
        db_1_s    = DbRs1;
        tr1_wr_en = 1'b1;
        state_d   = StRdB;
      end
      StRdB: begin
        tr2_wr_en = 1'b1;
        if (is_ld || is_sd) begin
          db_1_s  = DbOff;
          state_d = StAddr;
        end else begin
          db_0_s  = DbRs2;
          db_1_s  = DbRs2;
          state_d = is_r ? StExec : StCmp;
        end
      end
      StExec: begin
        alu_en    = 1'b1;
        alu_op    = opcode[ALU_OP_W-1:0];
        db_1_s    = DbAlu;
        tr2_wr_en = 1'b1;
        state_d   = StWb;
      end
      StCmp: begin
        alu_en = 1'b1;
        alu_op = ALU_OP_W'(AluSub);
        if ((is_beq && zero) || (is_blt && neg)) begin
          state_d = StBrPc;
        end else begin
          state_d = StPcInc;
        end
      end
      StBrPc: begin
        db_1_s    = DbPc;
        tr1_wr_en = 1'b1;
        state_d   = StBrOff;
      end
      StBrOff: begin
        db_1_s    = DbOff;
        tr2_wr_en = 1'b1;
        state_d   = StBrUpd;
      end
      StBrUpd: begin
        alu_en   = 1'b1;
        alu_op   = ALU_OP_W'(AluAdd);
        pc_wr_en = 1'b1;
        pc_src   = 1'b1;
        db_0_s   = DbPcmux;
        db_1_s   = DbAlu;
        state_d  = StFetch;
      end
      StAddr: begin
        alu_en    = 1'b1;
        alu_op    = ALU_OP_W'(AluAdd);
        db_1_s    = DbAlu;
        tr2_wr_en = 1'b1;
        state_d   = is_ld ? StMemRd : StStData;
      end
      StMemRd: begin
        dm_rd_en = 1'b1;
        if (dm_ready) begin
          db_1_s    = DbDm;
          tr1_wr_en = 1'b1;
          state_d   = StWb;
        end
      end
      StStData: begin
        db_0_s    = DbRs2;
        db_1_s    = DbRs2;
        tr1_wr_en = 1'b1;
        state_d   = StMemWr;
      end
      StMemWr: begin
        dm_wr_en = 1'b1;
        if (dm_ready) begin
          state_d = StPcInc;
        end
      end
      StWb: begin
        rf_wr_en = 1'b1;
        db_0_s   = DbRd;
        db_1_s   = is_ld ? DbTr1 : DbTr2;
        state_d  = StPcInc;
      end
      StPcInc: begin
        pc_wr_en = 1'b1;
        db_0_s   = DbPcmux;
        state_d  = StFetch;
      end
      StHalt: halted  = 1'b1;
      StTrap: illegal = 1'b1;
      default: state_d = StReset;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a table of single instructions with hand-computed
// per-instruction profiles, plus reset, halt and trap sequences.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        zero, neg, im_ready, dm_ready;
  logic        pc_wr_en, pc_src, ir_wr_en, rf_wr_en, tr1_wr_en, tr2_wr_en, alu_en;
  logic [3:0]  db_0_s, db_1_s;
  logic [1:0]  alu_op;
  logic        im_req, dm_rd_en, dm_wr_en, halted, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int Budget = 40;

  typedef struct {
    logic [3:0] opc;
    logic       z;
    logic       n;
    int imw, dmw;
    int cycles, rf, wb_sel, pc_wr, pc_src, dm_rd, dm_sel, dm_wr, exec_op, cmp_op;
  } vec_t;

  typedef struct {
    int cycles, rf, wb_sel, pc_wr, pc_src, dm_rd, dm_sel, dm_wr, exec_op, cmp_op, ir;
    int halted, illegal;
  } obs_t;

  vec_t vecs[12];
  obs_t o;

  mc_control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .zero       (zero),
    .neg        (neg),
    .im_ready   (im_ready),
    .dm_ready   (dm_ready),
    .pc_wr_en   (pc_wr_en),
    .pc_src     (pc_src),
    .ir_wr_en   (ir_wr_en),
    .rf_wr_en   (rf_wr_en),
    .tr1_wr_en  (tr1_wr_en),
    .tr2_wr_en  (tr2_wr_en),
    .alu_en     (alu_en),
    .db_0_s     (db_0_s),
    .db_1_s     (db_1_s),
    .alu_op     (alu_op),
    .im_req     (im_req),
    .dm_rd_en   (dm_rd_en),
    .dm_wr_en   (dm_wr_en),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic int all_outs();
    return int'({pc_wr_en, pc_src, ir_wr_en, rf_wr_en, tr1_wr_en, tr2_wr_en, alu_en,
                 db_0_s, db_1_s, alu_op, im_req, dm_rd_en, dm_wr_en, halted, illegal});
  endfunction

  task automatic check(input string what, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", what, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; runs until the next FETCH or the budget.
  task automatic run_instr(input logic [3:0] opc, input logic z, input logic n,
                           input int im_wait, input int dm_wait, output obs_t r);
    int  imw, dmw;
    bit  left_fetch;
    r = '{default: 0};
    imw = im_wait;
    dmw = dm_wait;
    left_fetch = 1'b0;
    instruction = {opc, 12'h321};
    zero = z;
    neg  = n;
    for (int c = 0; c < Budget; c++) begin
      if (!im_req) left_fetch = 1'b1;
      if (im_req && left_fetch) break;
      if (im_req && imw > 0) begin
        im_ready = 1'b0;
        imw--;
      end else begin
        im_ready = 1'b1;
      end
      if ((dm_rd_en || dm_wr_en) && dmw > 0) begin
        dm_ready = 1'b0;
        dmw--;
      end else begin
        dm_ready = 1'b1;
      end
      #1;
      r.cycles++;
      if (rf_wr_en) begin
        r.rf++;
        r.wb_sel = int'(db_1_s);
      end
      if (pc_wr_en) begin
        r.pc_wr++;
        r.pc_src = int'(pc_src);
      end
      if (dm_rd_en) r.dm_rd++;
      if (dm_rd_en && tr1_wr_en) r.dm_sel = int'(db_1_s);
      if (dm_wr_en) r.dm_wr++;
      if (alu_en && tr2_wr_en) r.exec_op = int'(alu_op);
      if (alu_en && !tr2_wr_en && !pc_wr_en) r.cmp_op = int'(alu_op);
      if (ir_wr_en) r.ir++;
      r.halted  = int'(halted);
      r.illegal = int'(illegal);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check({tag, ".rst_outs_zero"}, all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    im_ready = 1'b1;
    dm_ready = 1'b1;
    @(negedge clk);
    check({tag, ".fetch_after_rst"}, int'(im_req), 1);
  endtask

  initial begin
    rst = 1'b1;
    instruction = '0;
    zero = 1'b0;
    neg = 1'b0;
    im_ready = 1'b1;
    dm_ready = 1'b1;

    //         opc  z  n  imw dmw cyc rf wbs pcw src dmr dms dmw eop cop
    vecs[0]  = '{4'h0, 0, 0, 0, 0, 7, 1, 10, 1, 0, 0, 0, 0, 0, 0};   // ADD
    vecs[1]  = '{4'h1, 0, 0, 2, 0, 9, 1, 10, 1, 0, 0, 0, 0, 1, 0};   // SUB, 2 I-waits
    vecs[2]  = '{4'h4, 1, 0, 0, 0, 8, 0, 0, 1, 1, 0, 0, 0, 0, 1};    // BEQ taken
    vecs[3]  = '{4'h4, 0, 1, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1};    // BEQ not taken
    vecs[4]  = '{4'h5, 0, 1, 0, 0, 8, 0, 0, 1, 1, 0, 0, 0, 0, 1};    // BLT taken
    vecs[5]  = '{4'h5, 1, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1};    // BLT not taken
    vecs[6]  = '{4'h6, 0, 0, 0, 3, 11, 1, 11, 1, 0, 4, 14, 0, 0, 0}; // LD, 3 D-waits
    vecs[7]  = '{4'h6, 0, 0, 0, 0, 8, 1, 11, 1, 0, 1, 14, 0, 0, 0};  // LD
    vecs[8]  = '{4'h7, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, 1, 0, 0};    // SD
    vecs[9]  = '{4'h7, 0, 0, 0, 2, 10, 0, 0, 1, 0, 0, 0, 3, 0, 0};   // SD, 2 D-waits
    vecs[10] = '{4'h8, 0, 0, 1, 0, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0};    // JMP, 1 I-wait
    vecs[11] = '{4'h3, 0, 0, 1, 5, 8, 1, 10, 1, 0, 0, 0, 0, 3, 0};   // AND, stray dm wait

    #12;
    check("reset_outs_zero", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_fetch", int'(im_req), 1);

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].opc, vecs[i].z, vecs[i].n, vecs[i].imw, vecs[i].dmw, o);
      check($sformatf("vec%0d.cycles", i), o.cycles, vecs[i].cycles);
      check($sformatf("vec%0d.rf_wr", i), o.rf, vecs[i].rf);
      check($sformatf("vec%0d.wb_sel", i), o.wb_sel, vecs[i].wb_sel);
      check($sformatf("vec%0d.pc_wr", i), o.pc_wr, vecs[i].pc_wr);
      check($sformatf("vec%0d.pc_src", i), o.pc_src, vecs[i].pc_src);
      check($sformatf("vec%0d.dm_rd", i), o.dm_rd, vecs[i].dm_rd);
      check($sformatf("vec%0d.dm_sel", i), o.dm_sel, vecs[i].dm_sel);
      check($sformatf("vec%0d.dm_wr", i), o.dm_wr, vecs[i].dm_wr);
      check($sformatf("vec%0d.exec_op", i), o.exec_op, vecs[i].exec_op);
      check($sformatf("vec%0d.cmp_op", i), o.cmp_op, vecs[i].cmp_op);
      check($sformatf("vec%0d.ir_wr", i), o.ir, 1);
    end

    // Illegal opcode traps and never fetches again.
    run_instr(4'hA, 1'b0, 1'b0, 0, 0, o);
    check("trap.no_refetch", o.cycles, Budget);
    check("trap.illegal", o.illegal, 1);
    check("trap.halted", o.halted, 0);
    check("trap.req_idle", int'(im_req), 0);

    do_reset("after_trap");
    check("after_trap.illegal_clear", int'(illegal), 0);

    run_instr(4'hF, 1'b0, 1'b0, 0, 0, o);
    check("halt.no_refetch", o.cycles, Budget);
    check("halt.halted", o.halted, 1);
    check("halt.illegal", o.illegal, 0);

    do_reset("after_halt");

    // Reset in the middle of a stalled store.
    begin
      bit found = 1'b0;
      instruction = {4'h7, 12'h321};
      dm_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (dm_wr_en) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("memwr.reached", int'(found), 1);
      @(negedge clk);
      check("memwr.held", int'(dm_wr_en), 1);
      #2 rst = 1'b1;
      #1 check("memwr.rst_outs_zero", all_outs(), 0);
      @(negedge clk);
      check("memwr.rst_held_zero", all_outs(), 0);
      rst = 1'b0;
      dm_ready = 1'b1;
      @(negedge clk);
      check("memwr.fetch_after_rst", int'(im_req), 1);
      check("memwr.no_pc_wr", int'(pc_wr_en), 0);
      check("memwr.no_dm_wr", int'(dm_wr_en), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
